// File: rtl/down_timer_pkg.sv
// Shared definitions for the programmable down-timer and the control FSMs that consume its state encoding.
package down_timer_pkg;

   localparam int DEFAULT_BITS = 29;
   localparam int STATE_W      = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_DONE   = 2'd3
   } timer_state_e;

endpackage

// File: rtl/down_timer.sv
// Programmable interval timer: counts a loaded period down on the falling clock edge and
// emits a one-cycle Tick on expiry, either once (ending in DONE) or with auto-reload.
module down_timer
   import down_timer_pkg::*;
#(
   parameter int BITS = DEFAULT_BITS
) (
   input  logic            NEclk,
   input  logic            Nreset,
   input  logic            Load,
   input  logic [BITS-1:0] Period,
   input  logic            Start,
   input  logic            Stop,
   input  logic            AutoReload,
   output logic [BITS-1:0] count,
   output logic            Busy,
   output logic            Tick,
   output logic            Done
);

   localparam logic [BITS-1:0] ONE  = BITS'(1);
   localparam logic [BITS-1:0] ZERO = '0;

   timer_state_e    state_q, state_d;
   logic [BITS-1:0] count_q, count_d;
   logic [BITS-1:0] period_q, period_d;
   logic            tick_q, tick_d;
   logic            done_q, done_d;
   logic            start_go;

   // Stop outranks Start everywhere, so a simultaneous pair never starts anything.
   assign start_go = Start & ~Stop;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      period_d = period_q;
      tick_d   = 1'b0;
      done_d   = done_q;

      if (Load) begin
         period_d = Period;
         count_d  = Period;
         state_d  = ST_IDLE;
         done_d   = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start_go && (period_q != ZERO)) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (Stop) begin
                  state_d = ST_PAUSED;
               end else if (count_q > ONE) begin
                  count_d = count_q - ONE;
               end else begin
                  // Expiry; a zero count here is unreachable and is simply retired to DONE.
                  tick_d = (count_q == ONE);
                  if (AutoReload && (count_q == ONE)) begin
                     count_d = period_q;
                  end else begin
                     count_d = ZERO;
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end
               end
            end
            ST_PAUSED: begin
               if (start_go) begin
                  state_d = ST_RUN;
               end
            end
            ST_DONE: begin
               if (start_go) begin
                  count_d = period_q;
                  done_d  = 1'b0;
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(negedge NEclk or negedge Nreset) begin
      if (!Nreset) begin
         state_q  <= ST_IDLE;
         count_q  <= ZERO;
         period_q <= ZERO;
         tick_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         period_q <= period_d;
         tick_q   <= tick_d;
         done_q   <= done_d;
      end
   end

   assign count = count_q;
   assign Busy  = (state_q == ST_RUN);
   assign Tick  = tick_q;
   assign Done  = done_q;

endmodule

// File: tb/tb_down_timer.sv
// Randomized scoreboard bench for down_timer: a stimulus process pushes the reference model's
// expected outputs for each falling edge, and a monitor pops and compares them after that edge.
module tb_down_timer;

   localparam int BITS = 29;

   typedef struct packed {
      logic [BITS-1:0] count;
      logic            busy;
      logic            tick;
      logic            done;
   } expect_t;

   localparam int MODE_IDLE   = 10;
   localparam int MODE_RUN    = 11;
   localparam int MODE_PAUSED = 12;
   localparam int MODE_DONE   = 13;

   logic            NEclk;
   logic            Nreset;
   logic            Load;
   logic [BITS-1:0] Period;
   logic            Start;
   logic            Stop;
   logic            AutoReload;
   logic [BITS-1:0] count;
   logic            Busy;
   logic            Tick;
   logic            Done;

   int checks = 0;
   int fails  = 0;

   expect_t exp_q[$];

   int              m_mode;
   logic [BITS-1:0] m_count;
   logic [BITS-1:0] m_period;
   logic            m_tick;
   logic            m_done;

   down_timer #(.BITS(BITS)) dut (
      .NEclk      (NEclk),
      .Nreset     (Nreset),
      .Load       (Load),
      .Period     (Period),
      .Start      (Start),
      .Stop       (Stop),
      .AutoReload (AutoReload),
      .count      (count),
      .Busy       (Busy),
      .Tick       (Tick),
      .Done       (Done)
   );

   initial NEclk = 1'b1;
   always #5 NEclk = ~NEclk;

   task automatic check_output(input string tag, input expect_t e);
      checks++;
      if (count !== e.count) begin
         fails++;
         $display("[TB] FAIL %s.count at %0t: got %0d, expected %0d", tag, $time, count, e.count);
      end
      checks++;
      if (Busy !== e.busy) begin
         fails++;
         $display("[TB] FAIL %s.Busy at %0t: got %b, expected %b", tag, $time, Busy, e.busy);
      end
      checks++;
      if (Tick !== e.tick) begin
         fails++;
         $display("[TB] FAIL %s.Tick at %0t: got %b, expected %b", tag, $time, Tick, e.tick);
      end
      checks++;
      if (Done !== e.done) begin
         fails++;
         $display("[TB] FAIL %s.Done at %0t: got %b, expected %b", tag, $time, Done, e.done);
      end
   endtask

   function automatic expect_t model_view();
      expect_t e;
      e.count = m_count;
      e.busy  = (m_mode == MODE_RUN);
      e.tick  = m_tick;
      e.done  = m_done;
      return e;
   endfunction

   task automatic model_clear();
      m_mode   = MODE_IDLE;
      m_count  = '0;
      m_period = '0;
      m_tick   = 1'b0;
      m_done   = 1'b0;
   endtask

   // Behavioural reference: advances the timer by one falling edge from the spec's rules.
   task automatic model_step(input logic ld, input logic [BITS-1:0] per,
                             input logic sa, input logic st, input logic ar);
      m_tick = 1'b0;
      if (ld) begin
         m_period = per;
         m_count  = per;
         m_mode   = MODE_IDLE;
         m_done   = 1'b0;
      end else if (m_mode == MODE_RUN) begin
         if (st) begin
            m_mode = MODE_PAUSED;
         end else if (m_count == 1) begin
            m_tick = 1'b1;
            if (ar) begin
               m_count = m_period;
            end else begin
               m_count = '0;
               m_mode  = MODE_DONE;
               m_done  = 1'b1;
            end
         end else begin
            m_count = m_count - 1'b1;
         end
      end else if (sa && !st) begin
         if (m_mode == MODE_IDLE && m_period != 0) begin
            m_mode = MODE_RUN;
         end else if (m_mode == MODE_PAUSED) begin
            m_mode = MODE_RUN;
         end else if (m_mode == MODE_DONE) begin
            m_count = m_period;
            m_done  = 1'b0;
            m_mode  = MODE_RUN;
         end
      end
   endtask

   task automatic apply_stimulus(input logic ld, input logic [BITS-1:0] per,
                                 input logic sa, input logic st, input logic ar);
      @(posedge NEclk);
      Nreset     = 1'b1;
      Load       = ld;
      Period     = per;
      Start      = sa;
      Stop       = st;
      AutoReload = ar;
      model_step(ld, per, sa, st, ar);
      exp_q.push_back(model_view());
   endtask

   task automatic idle_cycles(input int n, input logic ar);
      for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, 1'b0, 1'b0, ar);
   endtask

   // Asserts reset between edges and checks the outputs clear with no clock edge.
   task automatic async_reset();
      @(posedge NEclk);
      #1;
      Nreset     = 1'b0;
      Load       = 1'b0;
      Start      = 1'b0;
      Stop       = 1'b0;
      AutoReload = 1'b0;
      #1;
      model_clear();
      check_output("async_reset", model_view());
      exp_q.push_back(model_view());
   endtask

   initial begin
      expect_t e;
      forever begin
         @(negedge NEclk);
         #2;
         checks++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_empty at %0t: got 0 entries, expected 1", $time);
         end else begin
            e = exp_q.pop_front();
            check_output("edge", e);
         end
      end
   end

   initial begin
      logic            ld, sa, st, ar;
      logic [BITS-1:0] per;

      Nreset     = 1'b0;
      Load       = 1'b0;
      Period     = '0;
      Start      = 1'b0;
      Stop       = 1'b0;
      AutoReload = 1'b0;
      #1;
      model_clear();
      check_output("power_on_reset", model_view());
      exp_q.push_back(model_view());

      apply_stimulus(1'b1, BITS'(10), 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      idle_cycles(3, 1'b0);
      async_reset();

      apply_stimulus(1'b1, BITS'(5), 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      idle_cycles(7, 1'b0);

      apply_stimulus(1'b1, BITS'(3), 1'b0, 1'b0, 1'b1);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
      idle_cycles(10, 1'b1);

      apply_stimulus(1'b1, BITS'(6), 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      idle_cycles(2, 1'b0);
      apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
      apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
      idle_cycles(3, 1'b0);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      idle_cycles(6, 1'b0);

      apply_stimulus(1'b1, BITS'(9), 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      idle_cycles(2, 1'b0);
      apply_stimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
      idle_cycles(1, 1'b0);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b1, BITS'(7), 1'b1, 1'b1, 1'b0);
      apply_stimulus(1'b1, BITS'(0), 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      idle_cycles(4, 1'b0);

      apply_stimulus(1'b1, BITS'(1), 1'b0, 1'b0, 1'b1);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
      idle_cycles(5, 1'b1);
      apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);

      ar = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 249) == 0) begin
            async_reset();
         end else begin
            ld  = ($urandom_range(0, 99) < 6);
            per = ($urandom_range(0, 19) == 0) ? BITS'($urandom) : BITS'($urandom_range(0, 9));
            sa  = ($urandom_range(0, 99) < 20);
            st  = ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 9) == 0) ar = ~ar;
            apply_stimulus(ld, per, sa, st, ar);
         end
      end

      @(negedge NEclk);
      #4;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
